vram_port_arbiter: RTL
======================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single-word SDRAM FIFO port (write_ld/write_req, read_ld/read_req) between
//  two game-logic write clients and one video-fetch read client. Sequences each access:
//  address load, settle wait, FIFO-status wait, request pulse, capture. Sits between the
//  tetris game/render logic and the SDRAM controller FIFOs. Replaces hand-unrolled write/read FSMs.
// PARAMETERS
//  ADDR_W   25    SDRAM word address width
//  DATA_W   16    data word width
//  SETTLE   8     cycles held in *_WAIT after an address load before a request is allowed (>=1)
//  TIMEOUT  1024  max total cycles in *_WAIT before the access is aborted (>SETTLE)
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  w0_req       in   1       write client 0 request; hold with addr/data until w0_ack
//  w0_addr      in   ADDR_W  write client 0 address
//  w0_data      in   DATA_W  write client 0 data
//  w0_ack       out  1       one-cycle pulse: client 0 write finished (or aborted)
//  w1_req/w1_addr/w1_data/w1_ack   same as client 0, for client 1
//  r_req        in   1       read client request; hold with r_addr until r_valid
//  r_addr       in   ADDR_W  read address
//  r_valid      out  1       one-cycle pulse: r_data valid (or aborted, see r_err)
//  r_data       out  DATA_W  read result; holds until next read completes
//  r_err        out  1       qualifies r_valid: 1 = read aborted by timeout, r_data = 0
//  write_ld     out  1       SDRAM write FIFO clear/address load strobe
//  writeaddr    out  ADDR_W  SDRAM write address
//  write_req    out  1       SDRAM write request strobe
//  writedata    out  DATA_W  SDRAM write data
//  wr_full      in   1       SDRAM write FIFO full
//  read_ld      out  1       SDRAM read FIFO clear/address load strobe
//  readaddr     out  ADDR_W  SDRAM read address
//  read_req     out  1       SDRAM read request strobe
//  rd_empty     in   1       SDRAM read FIFO empty
//  readdata     in   DATA_W  SDRAM read FIFO output
//  busy         out  1       state != IDLE
//  timeout_err  out  1       sticky: any access aborted; cleared only by reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; every output 0; rr_last=1 (W0 favoured first); counter=0.
//  Strobes are Moore-decoded from registered state: write_ld=W_LD, write_req=W_REQ,
//   read_ld=R_LD, read_req=R_REQ, w*_ack/r_valid=W_DONE/R_DONE. Each is exactly 1 cycle high.
//  Grant (IDLE only): r_req wins (strict priority); else if both w0/w1, grant != rr_last;
//   else the single requester. On grant, addr (and data) latched into writeaddr/writedata
//   or readaddr; these hold until the next grant. rr_last updates on write grant only.
//  Write FSM: IDLE->W_LD (1 cyc)->W_WAIT->W_REQ (1)->W_DONE (1, ack to granted client)->IDLE.
//   W_WAIT: cnt counts from 0; exit to W_REQ when cnt>=SETTLE-1 and !wr_full.
//  Read FSM: IDLE->R_LD->R_WAIT->R_REQ->R_CAP->R_DONE->IDLE.
//   R_WAIT: exit when cnt>=SETTLE-1 and !rd_empty. R_CAP: r_data<=readdata at its end.
//   R_DONE: r_valid=1, r_err=0.
//  Latency (grant edge to ack/valid cycle, no backpressure): write SETTLE+3, read SETTLE+4.
//  Timeout: if cnt reaches TIMEOUT-1 in *_WAIT, skip request: write->W_DONE (ack, no write_req);
//   read->R_DONE with r_err=1, r_data=0; timeout_err<=1. cnt width = $clog2(TIMEOUT).
//  Clients: req must stay high until ack; a req seen in IDLE after ack is a new request.
//   Dropping req mid-access does not abort it; the ack/valid still pulses.
//  Simultaneous r_req and w*_req in IDLE: read first; writes served on next IDLE cycle.
//  Read strictly preempts writes only between accesses, never mid-access.
//  Back-to-back: one IDLE cycle between consecutive accesses (no IDLE skip).
// TESTING
//  1 Reset then w0_req, addr=0x3, data=0x00A5, wr_full=0 -> write_ld 1 cyc, write_req 1 cyc
//    with writeaddr=0x3, writedata=0x00A5, w0_ack on cycle SETTLE+3=11 after grant.
//  2 w0_req and w1_req held together for 4 accesses -> grants W0,W1,W0,W1; never same twice.
//  3 r_req and w1_req same cycle; r_addr=0x3, rd_empty=1 for 20 cycles, readdata=0x1234 ->
//    read first, read_req only after rd_empty falls, r_valid with r_data=0x1234, then w1 write.
//  4 wr_full held 1 with TIMEOUT=64 -> no write_req, w0_ack after timeout, timeout_err=1 sticky;
//    same for rd_empty=1 -> r_valid with r_err=1, r_data=0.
//  5 reset_n low in W_WAIT and in R_CAP -> all outputs 0 immediately, IDLE, rr_last=1,
//    timeout_err cleared; next request starts cleanly.
//  6 w0_req dropped during W_WAIT -> write still issued, w0_ack still pulses once.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Arbitrates two write clients and one read client onto the single-word SDRAM FIFO port,
// sequencing each access through address load, settle/status wait, request and completion.
module vram_port_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ack,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ack,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic              r_err,
    output logic              write_ld,
    output logic [ADDR_W-1:0] writeaddr,
    output logic              write_req,
    output logic [DATA_W-1:0] writedata,
    input  logic              wr_full,
    output logic              read_ld,
    output logic [ADDR_W-1:0] readaddr,
    output logic              read_req,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_LD   = 4'd1,
        W_WAIT = 4'd2,
        W_REQ  = 4'd3,
        W_DONE = 4'd4,
        R_LD   = 4'd5,
        R_WAIT = 4'd6,
        R_REQ  = 4'd7,
        R_CAP  = 4'd8,
        R_DONE = 4'd9
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               rr_last_r;
    logic               wsel_r;
    logic               grant_w_s;
    logic               grant_sel_s;
    logic               abort_s;
    logic               settle_ok_s;
    logic               expired_s;

    assign settle_ok_s = (cnt_r >= CNT_W'(SETTLE - 1));
    assign expired_s   = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Next-state, grant selection and timeout abort decode
    always_comb begin
        state_s     = state_r;
        grant_w_s   = 1'b0;
        grant_sel_s = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (r_req) begin
                    state_s = R_LD;
                end else if (w0_req || w1_req) begin
                    state_s   = W_LD;
                    grant_w_s = 1'b1;
                    // rr_last names the last write client served; the other one goes next
                    if (w0_req && w1_req) begin
                        grant_sel_s = ~rr_last_r;
                    end else begin
                        grant_sel_s = w1_req;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            W_LD:   state_s = W_WAIT;
            W_WAIT: begin
                if (settle_ok_s && !wr_full) begin
                    state_s = W_REQ;
                end else if (expired_s) begin
                    state_s = W_DONE;
                    abort_s = 1'b1;
                end else begin
                    state_s = W_WAIT;
                end
            end
            W_REQ:  state_s = W_DONE;
            W_DONE: state_s = IDLE;
            R_LD:   state_s = R_WAIT;
            R_WAIT: begin
                if (settle_ok_s && !rd_empty) begin
                    state_s = R_REQ;
                end else if (expired_s) begin
                    state_s = R_DONE;
                    abort_s = 1'b1;
                end else begin
                    state_s = R_WAIT;
                end
            end
            R_REQ:  state_s = R_CAP;
            R_CAP:  state_s = R_DONE;
            R_DONE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, wait counter, latched access parameters and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rr_last_r   <= 1'b1;
            wsel_r      <= 1'b0;
            writeaddr   <= {ADDR_W{1'b0}};
            writedata   <= {DATA_W{1'b0}};
            readaddr    <= {ADDR_W{1'b0}};
            r_data      <= {DATA_W{1'b0}};
            r_err       <= 1'b0;
            timeout_err <= 1'b0;
            write_ld    <= 1'b0;
            write_req   <= 1'b0;
            read_ld     <= 1'b0;
            read_req    <= 1'b0;
            w0_ack      <= 1'b0;
            w1_ack      <= 1'b0;
            r_valid     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == W_WAIT) || (state_r == R_WAIT)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (grant_w_s) begin
                wsel_r    <= grant_sel_s;
                rr_last_r <= grant_sel_s;
                writeaddr <= grant_sel_s ? w1_addr : w0_addr;
                writedata <= grant_sel_s ? w1_data : w0_data;
            end
            if ((state_r == IDLE) && (state_s == R_LD)) begin
                readaddr <= r_addr;
            end
            // An aborted read reports zero data alongside r_err
            if (state_r == R_CAP) begin
                r_data <= readdata;
            end else if (abort_s && (state_r == R_WAIT)) begin
                r_data <= {DATA_W{1'b0}};
            end
            if (abort_s) begin
                timeout_err <= 1'b1;
            end
            r_err     <= abort_s && (state_r == R_WAIT);
            write_ld  <= (state_s == W_LD);
            write_req <= (state_s == W_REQ);
            read_ld   <= (state_s == R_LD);
            read_req  <= (state_s == R_REQ);
            w0_ack    <= (state_s == W_DONE) && !wsel_r;
            w1_ack    <= (state_s == W_DONE) && wsel_r;
            r_valid   <= (state_s == R_DONE);
            busy      <= (state_s != IDLE);
        end
    end

endmodule
